point_weights_buffer: RTL

// - Parametrised 1x1 (pointwise) weight store for the bneck point-conv engine.
// - Loads weights through a streaming valid/ready port, one filter vector per beat, and packs

---
 rtl/point_weights_buffer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/point_weights_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : point_weights_buffer
//  Purpose  : Pointwise (1x1) weight store for the bneck point-conv engine.
//             Weights stream in one filter vector per beat. FILTERS beats are
//             packed into one row, and a load session writes a run of rows
//             starting at a programmable base. Rows are read out one full row
//             per request.
//  Options  : POINT_WBUF_RD_REG_EN - adds an output register on the read
//             path, so the read latency goes from 1 to 2 cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module point_weights_buffer #(
  parameter int DATA_WIDTH = 14,
  parameter int LANES      = 16,
  parameter int FILTERS    = 16,
  parameter int DEPTH      = 938,
  parameter int ADDR_W     = 10
) (
  input  logic                                  clk,
  input  logic                                  rst,
  // load port
  input  logic                                  ld_start_i,
  input  logic [ADDR_W-1:0]                     ld_base_i,
  input  logic [ADDR_W-1:0]                     ld_rows_i,
  input  logic                                  ld_valid_i,
  input  logic [LANES*DATA_WIDTH-1:0]           ld_data_i,
  output logic                                  ld_ready_o,
  output logic                                  ld_busy_o,
  output logic                                  ld_done_o,
  output logic                                  ld_err_o,
  // read port
  input  logic                                  rd_en_i,
  input  logic [ADDR_W-1:0]                     rd_index_i,
  output logic [FILTERS*LANES*DATA_WIDTH-1:0]   rd_data_o,
  output logic                                  rd_valid_o
);

  localparam int VEC_W  = LANES * DATA_WIDTH;
  localparam int ROW_W  = FILTERS * VEC_W;
  localparam int BEAT_W = (FILTERS > 1) ? $clog2(FILTERS) : 1;

  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FILTERS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_COMMIT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                          state_q;
  logic [ADDR_W-1:0]               wr_ptr_q;
  logic [ADDR_W-1:0]               rows_left_q;
  logic [BEAT_W-1:0]               beat_cnt_q;
  logic [FILTERS-1:0][VEC_W-1:0]   asm_q;
  logic                            ready_q;
  logic                            busy_q;
  logic                            done_q;
  logic                            err_q;

  logic [ROW_W-1:0]                mem [DEPTH];

  logic                            rd_valid_q;
  logic [ROW_W-1:0]                rd_data_q;

  // A session must be non-empty and must end at or below the last row.
  // The sum is taken one bit wider so that it cannot wrap.
  logic start_ok_d;
  assign start_ok_d = (ld_rows_i != '0) &&
                      (({1'b0, ld_base_i} + {1'b0, ld_rows_i}) <= DEPTH_X);

  logic rd_in_range_d;
  assign rd_in_range_d = ({1'b0, rd_index_i} < DEPTH_X);

  // Load-session FSM: assembles beats into a row and sequences commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rows_left_q <= '0;
      beat_cnt_q  <= '0;
      asm_q       <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ld_start_i) begin
            if (start_ok_d) begin
              state_q     <= S_LOAD;
              wr_ptr_q    <= ld_base_i;
              rows_left_q <= ld_rows_i;
              beat_cnt_q  <= '0;
              ready_q     <= 1'b1;
              busy_q      <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (ld_valid_i && ready_q) begin
            asm_q[beat_cnt_q] <= ld_data_i;
            beat_cnt_q        <= beat_cnt_q + BEAT_W'(1);
            if (beat_cnt_q == LAST_BEAT) begin
              state_q <= S_COMMIT;
              ready_q <= 1'b0;
            end
          end
        end
        S_COMMIT: begin
          wr_ptr_q    <= wr_ptr_q + ADDR_W'(1);
          rows_left_q <= rows_left_q - ADDR_W'(1);
          if (rows_left_q == ADDR_W'(1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q    <= S_LOAD;
            beat_cnt_q <= '0;
            ready_q    <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Row storage: no reset, so weights survive a reset. Commits are blocked
  // while reset is held.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == S_COMMIT)) begin
      mem[wr_ptr_q] <= asm_q;
    end
  end

  // First read stage: the registered read returns the pre-commit contents
  // when it hits the row being committed. Out-of-range indices read as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_en_i;
      if (rd_en_i) begin
        rd_data_q <= rd_in_range_d ? mem[rd_index_i] : '0;
      end
    end
  end

`ifdef POINT_WBUF_RD_REG_EN
  logic             rd_valid_p_q;
  logic [ROW_W-1:0] rd_data_p_q;

  // Extra output stage: data advances only with a valid read, so the last
  // row read is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_p_q <= 1'b0;
      rd_data_p_q  <= '0;
    end else begin
      rd_valid_p_q <= rd_valid_q;
      if (rd_valid_q) begin
        rd_data_p_q <= rd_data_q;
      end
    end
  end

  assign rd_valid_o = rd_valid_p_q;
  assign rd_data_o  = rd_data_p_q;
`else
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
`endif

  assign ld_ready_o = ready_q;
  assign ld_busy_o  = busy_q;
  assign ld_done_o  = done_q;
  assign ld_err_o   = err_q;

endmodule
`default_nettype wire
